// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that shares one UART transmitter among NREQ byte-stream requesters.
// A grant lasts for a whole packet, a MAX_BURST byte budget, or until HOLD_TIMEOUT idle cycles pass.
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 64,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_transmit,
    output logic [7:0]        uart_tx_byte,
    input  logic              uart_tx_free,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout_err
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, SEND, ISSUE, WAIT_BUSY, WAIT_FREE} state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic [15:0]      idle_cnt_q, idle_cnt_d;
    logic             last_f_q, last_f_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             transmit_q, transmit_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [PTR_W-1:0] pick;
    logic [PTR_W-1:0] cand;

    // The search starts just after the last owner, so whoever was served last has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        last_f_d    = last_f_q;
        tx_byte_d   = tx_byte_q;
        transmit_d  = 1'b0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_tx_free && found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    rr_ptr_d      = pick;
                    burst_cnt_d   = 8'd0;
                    idle_cnt_d    = 16'd0;
                    state_d       = SEND;
                end
            end
            SEND: begin
                // An arriving byte wins over the timeout in the same cycle.
                if (req_valid[rr_ptr_q] && uart_tx_free) begin
                    tx_byte_d   = req_data[{rr_ptr_q, 3'b000} +: 8];
                    last_f_d    = req_last[rr_ptr_q];
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    idle_cnt_d  = 16'd0;
                    transmit_d  = 1'b1;
                    state_d     = ISSUE;
                end else if (idle_cnt_q == 16'(HOLD_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            ISSUE: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!uart_tx_free) state_d = WAIT_FREE;
            end
            WAIT_FREE: begin
                if (uart_tx_free) begin
                    if (last_f_q || burst_cnt_q == 8'(MAX_BURST)) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= PTR_W'(NREQ - 1);
            burst_cnt_q <= 8'd0;
            idle_cnt_q  <= 16'd0;
            last_f_q    <= 1'b0;
            tx_byte_q   <= 8'd0;
            transmit_q  <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_f_q    <= last_f_d;
            tx_byte_q   <= tx_byte_d;
            transmit_q  <= transmit_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready     = grant_q & {NREQ{(state_q == SEND) && uart_tx_free}};
    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_q;

endmodule
